// File: rtl/mem_responder_if.sv
// Memory request/response bundle between an initiator (master) and mem_responder (slave).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_misaligned;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp, mem_misaligned
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp, mem_misaligned
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed single-port memory responder with programmable latency and byte-masked writes.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned accesses and suppress misaligned writes.
module mem_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            wr_allow;
  logic            mem_we;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Upper address bits alias and the byte offset never selects data.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_address[31:IdxW+2], bus.mem_address[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_read | bus.mem_write) begin
          idx_d   = bus.mem_address[IdxW+1:2];
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          write_d = bus.mem_write;
          cnt_d   = LoadCnt;
          state_d = (LoadCnt == 4'd0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Read data is registered on the edge that enters the response cycle.
    if ((state_d == StResp) && (state_q != StResp) && !write_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if ((state_q == StIdle) && (bus.mem_read | bus.mem_write)) begin
      mis_d = (bus.mem_address[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign wr_allow           = !mis_q;
  assign bus.mem_misaligned = (state_q == StResp) && mis_q;
`else
  assign wr_allow           = 1'b1;
  assign bus.mem_misaligned = 1'b0;
`endif

  // Commit happens on the edge leaving the response cycle, so a reset there discards it.
  assign mem_we = (state_q == StResp) && write_q && wr_allow;

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_resp  = (state_q == StResp);
  assign bus.mem_rdata = rdata_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed, single-port memory responder for the RV32I core's memory interface. It is the far end of the core's `mem_read`/`mem_write`/`mem_resp` handshake: it serves load/store requests from the MAR/MDR side of the datapath. Access latency is programmable and byte-lane writes are masked. It backs instruction and data ports in block-level and core-level simulation, and is the stand-in for the later cache hierarchy.

## Interface
- `LATENCY`, default 2: cycles from request sample to `mem_resp`; legal range 1..15.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: read request, held by the initiator until `mem_resp`.
- `mem_write` in 1: write request, held until `mem_resp`.
- `mem_address` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_byte_enable` in 4: write lane mask; bit i enables byte i (bits [8i+7:8i]).
- `mem_rdata` out 32: read data, valid in the `mem_resp` cycle.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_misaligned` out 1: alignment flag; see Configuration.

## Operation
- Reset values: `mem_resp`=0, `mem_rdata`=0, `mem_misaligned`=0, state IDLE, latency counter 0. Array contents are not reset and persist across `rst`.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - When `mem_read|mem_write` is high, capture address, wdata, byte_enable and op. Load the counter with LATENCY-1.
  - If the loaded value is 0, go to RESP; otherwise go to BUSY.
- BUSY: decrement the counter each cycle. When it reaches 0, go to RESP.
- RESP:
  - Assert `mem_resp` for exactly one cycle, then return to IDLE.
  - Reads: `mem_rdata` = array[captured index].
  - Writes: commit enabled bytes on the RESP-cycle edge. `mem_rdata` holds its previous value.
- Word index is `mem_address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4. Bits [1:0] are ignored for the access.
- Simultaneous `mem_read` and `mem_write`: write wins and the read is dropped. `mem_rdata` is not updated.
- Request inputs are ignored outside IDLE:
  - Changes to the inputs in BUSY/RESP have no effect.
  - An initiator deasserting its request early does not cancel the captured access. It still completes and pulses `mem_resp`.
- `mem_byte_enable`=0 on a write: completes normally with `mem_resp`; no array change.
- Read-after-write to the same word returns the newly written bytes, merged with the unchanged bytes.
- `rst` in BUSY or RESP: return to IDLE. No `mem_resp`, and any pending write is discarded uncommitted.

## Timing
- Request sampled high in IDLE at cycle N → `mem_resp`=1 in cycle N+LATENCY. Data is valid in the same cycle.
- The cycle after RESP is IDLE. A request still held high there is sampled as a new access.
  - Back-to-back throughput is one access per LATENCY+1 cycles.
- `mem_rdata` is registered: it changes only on the edge entering RESP, and holds until the next read completes.
- A request is never accepted in the same cycle as `mem_resp`.

## Configuration
- `MEM_RESPONDER_ALIGN_CHECK_EN` defined:
  - In RESP, `mem_misaligned`=1 if the captured `mem_address[1:0]` != 2'b00.
  - A misaligned write is suppressed: no bytes are committed.
  - A misaligned read returns data as normal.
  - `mem_misaligned` is 0 in all other cycles.
- Not defined: `mem_misaligned` is tied to 0, and misaligned writes commit using bits [1:0] ignored.

## Test plan
- LATENCY=2. Write 0xDEADBEEF to 0x100 with be=4'hF, then read 0x100 → `mem_resp` at N+2 for each access; rdata=0xDEADBEEF in the read's resp cycle.
- Over word 0x11223344 at 0x40, write 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD.
- LATENCY=1, `mem_read` held high continuously at 0x0, 0x4 → `mem_resp` pulses every 2 cycles, never on 2 consecutive cycles.
- Assert `rst` in the BUSY cycle of a write of 0x5 to 0x8 (prior content 0x0) → no `mem_resp`; a subsequent read of 0x8 returns 0x0.
- `mem_read` and `mem_write` both high; write of 0xCAFEF00D to 0x20 → `mem_resp` once; a later read of 0x20 returns 0xCAFEF00D; `mem_rdata` unchanged in the first resp.
- With `MEM_RESPONDER_ALIGN_CHECK_EN`: write 0x1 to 0x22 → `mem_misaligned`=1 with `mem_resp`; a read of 0x20 returns the prior value. Without the macro: flag stays 0 and 0x20 reads 0x1.
